capture_sched: RTL and testbench
================================

CAPTURE_SCHED -- requirements
Module: capture_sched

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, giving the clk100_i cycles per auto-tick (1 ms at 100 MHz).
REQ-002 SHALL have parameter GAP, default 4, giving the cooldown cycles after each capture.
REQ-003 SHALL have port clk100_i, input, 1 bit: single system clock, rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port man_req_i, input, 1 bit: one-cycle manual capture pulse from a debounced key.
REQ-006 SHALL have port clr_req_i, input, 1 bit: one-cycle clear pulse from a debounced key.
REQ-007 SHALL have port auto_en_i, input, 1 bit: auto-capture enable.
REQ-008 SHALL have port period_i, input, 4 bits: auto interval of (period_i+1) ticks.
REQ-009 SHALL have port sw_i, input, 10 bits: switch data to capture.
REQ-010 SHALL have port data_o, output, 10 bits: last captured switch word.
REQ-011 SHALL have port count_o, output, 8 bits: capture count, feeds hex display.
REQ-012 SHALL have port src_o, output, 2 bits: source of the last capture (0 none, 1 manual, 2 auto).
REQ-013 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have port ovf_o, output, 1 bit: sticky count-wrap flag.
REQ-015 SHALL have port miss_o, output, 1 bit: one-cycle pulse when a request merges into an already-pending one.

Function
REQ-016 SHALL keep pending flags pend_man and pend_auto; a request sets its flag at the sampling edge.
REQ-017 SHALL run FSM IDLE -> GRANT -> WRITE -> COOL -> IDLE.
REQ-018 IDLE: any pending flag -> GRANT, latching the winner and clearing its flag; otherwise stay in IDLE.
REQ-019 When both flags are pending, SHALL grant the source not granted last (round-robin); after reset, manual wins.
REQ-020 WRITE edge: data_o<=sw_i, count_o<=count_o+1, src_o<=winner.
REQ-021 COOL: stay exactly GAP cycles, then IDLE; requests arriving in GRANT/WRITE/COOL set pending and are served afterwards.
REQ-022 Latency: a request sampled in cycle c, with FSM idle, SHALL show new data_o/count_o in cycle c+3.
REQ-023 A request whose flag is already set SHALL pulse miss_o next cycle and not double-count.
REQ-024 count_o SHALL wrap 8'hFF->8'h00 modulo 256, setting ovf_o sticky on the wrap.
REQ-025 clr_req_i SHALL have top priority in any state: next edge sets data_o=0, count_o=0, src_o=0, ovf_o=0, clears both pending flags, and enters IDLE.
REQ-026 A request in the same cycle as clr_req_i SHALL be discarded.
REQ-027 Auto: the prescaler SHALL emit a tick every TICK_DIV cycles, and the interval counter SHALL set pend_auto on every (period_i+1)th tick.
REQ-028 auto_en_i low SHALL hold the prescaler and interval counter at 0 and clear pend_auto, unless pend_auto is being granted that cycle.
REQ-029 A period_i change SHALL take effect at the next interval-counter reload; the current interval SHALL NOT be truncated.

Reset
REQ-030 rst_i high at an edge SHALL set state IDLE, data_o=0, count_o=0, src_o=0, busy_o=0, ovf_o=0, miss_o=0, pending flags and round-robin pointer to 0, and prescaler and interval counter to 0.
REQ-031 Reset mid-capture SHALL abort without a partial update; rst_i SHALL override clr_req_i and requests.

Structure
REQ-032 Package capture_pkg SHALL hold the state enum, source codes SRC_NONE/SRC_MAN/SRC_AUTO, and widths 10/8/4.
REQ-033 Sub-module tick_gen SHALL contain the prescaler and interval counter (inputs: enable, period; output: 1-cycle auto request).
REQ-034 Outputs SHALL be registered, with no combinational input-to-output path.

Verification (TICK_DIV=4, GAP=4)
REQ-035 Manual pulse with sw_i=10'h2A5 -> data_o=10'h2A5, count_o=8'h01, src_o=1, and busy_o high for 1+1+4 cycles.
REQ-036 man_req_i and auto request sampled in the same cycle -> two captures: manual first, then auto after cooldown; count_o=8'h02.
REQ-037 256 manual captures from count_o=8'hFF-1 boundary -> count_o goes FE, FF, 00, with ovf_o=1 from the wrap onward.
REQ-038 clr_req_i asserted during the WRITE edge with a pending auto request -> all outputs 0, FSM IDLE, no further capture.
REQ-039 auto_en_i=1, period_i=2 -> pend_auto every 12 cycles; two man_req_i pulses during COOL -> miss_o pulses once.

Source files
------------

// File: rtl/capture_pkg.sv
// capture_pkg: shared types and widths for the capture scheduler.
//   state_e : scheduler FSM states
//   src_e   : capture source codes reported on src_o
//   cnt_inc : counter increment that also returns the wrap carry
package capture_pkg;

    localparam int DATA_W = 10;
    localparam int CNT_W  = 8;
    localparam int PER_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2,
        ST_COOL  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MAN  = 2'd1,
        SRC_AUTO = 2'd2
    } src_e;

    // Returns {carry, v+1}; carry is set exactly on the FF->00 wrap.
    function automatic logic [CNT_W:0] cnt_inc(input logic [CNT_W-1:0] v);
        return {1'b0, v} + {{CNT_W{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/capture_sched_tick_gen.sv
// tick_gen: auto-capture timebase.
//   clk100_i   : system clock
//   rst_i      : synchronous active-high reset
//   en_i       : auto enable; low holds both counters at zero
//   period_i   : interval of (period_i+1) ticks, latched at each reload
//   auto_req_o : registered one-cycle auto capture request
module tick_gen
    import capture_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic             clk100_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [PER_W-1:0] period_i,
    output logic             auto_req_o
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PER_W-1:0] ivl_q, ivl_d;
    logic [PER_W-1:0] lim_q, lim_d;
    logic             req_q, req_d;

    // Prescaler and interval counter next-state; the limit is only taken from
    // period_i while disabled or at a reload so a running interval is never cut short.
    always_comb begin
        pre_d = pre_q;
        ivl_d = ivl_q;
        lim_d = lim_q;
        req_d = 1'b0;
        if (!en_i) begin
            pre_d = {PRE_W{1'b0}};
            ivl_d = {PER_W{1'b0}};
            lim_d = period_i;
        end else if (pre_q == PRE_W'(TICK_DIV - 1)) begin
            pre_d = {PRE_W{1'b0}};
            if (ivl_q == lim_q) begin
                req_d = 1'b1;
                ivl_d = {PER_W{1'b0}};
                lim_d = period_i;
            end else begin
                ivl_d = ivl_q + {{(PER_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pre_d = pre_q + {{(PRE_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter state registers.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            pre_q <= {PRE_W{1'b0}};
            ivl_q <= {PER_W{1'b0}};
            lim_q <= {PER_W{1'b0}};
            req_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            ivl_q <= ivl_d;
            lim_q <= lim_d;
            req_q <= req_d;
        end
    end

    assign auto_req_o = req_q;

endmodule

// File: rtl/capture_sched.sv
// capture_sched: arbitrates manual and periodic auto capture requests and
// latches the switch word with a running count.
//   clk100_i, rst_i          : clock, synchronous active-high reset
//   man_req_i, clr_req_i     : one-cycle manual capture / clear pulses
//   auto_en_i, period_i      : auto enable and interval (period_i+1 ticks)
//   sw_i                     : word to capture
//   data_o, count_o, src_o   : last word, capture count, last source
//   busy_o, ovf_o, miss_o    : FSM not idle, sticky wrap, merged-request pulse
module capture_sched
    import capture_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int GAP      = 4
) (
    input  logic              clk100_i,
    input  logic              rst_i,
    input  logic              man_req_i,
    input  logic              clr_req_i,
    input  logic              auto_en_i,
    input  logic [PER_W-1:0]  period_i,
    input  logic [DATA_W-1:0] sw_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [1:0]        src_o,
    output logic              busy_o,
    output logic              ovf_o,
    output logic              miss_o
);

    localparam int COOL_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_e            state_q, state_d;
    src_e              win_q, win_d;
    logic              pend_man_q, pend_man_d;
    logic              pend_auto_q, pend_auto_d;
    logic              rr_q, rr_d;          // 1: auto is preferred on the next tie
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        src_q, src_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              miss_q, miss_d;
    logic [COOL_W-1:0] cool_q, cool_d;
    logic              auto_req_s;
    logic              grant_man_s, grant_auto_s;
    logic [CNT_W:0]    inc_s;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk100_i   (clk100_i),
        .rst_i      (rst_i),
        .en_i       (auto_en_i),
        .period_i   (period_i),
        .auto_req_o (auto_req_s)
    );

    // FSM, arbitration and pending-flag next-state. The capture is committed on
    // the edge leaving GRANT so the new word is visible during WRITE.
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        pend_man_d   = pend_man_q;
        pend_auto_d  = pend_auto_q;
        rr_d         = rr_q;
        data_d       = data_q;
        count_d      = count_q;
        src_d        = src_q;
        ovf_d        = ovf_q;
        cool_d       = cool_q;
        miss_d       = 1'b0;
        grant_man_s  = 1'b0;
        grant_auto_s = 1'b0;
        inc_s        = cnt_inc(count_q);

        case (state_q)
            ST_IDLE: begin
                if (pend_man_q && (!pend_auto_q || !rr_q)) begin
                    grant_man_s = 1'b1;
                    win_d       = SRC_MAN;
                    rr_d        = 1'b1;
                    state_d     = ST_GRANT;
                end else if (pend_auto_q) begin
                    grant_auto_s = 1'b1;
                    win_d        = SRC_AUTO;
                    rr_d         = 1'b0;
                    state_d      = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                data_d  = sw_i;
                count_d = inc_s[CNT_W-1:0];
                src_d   = win_q;
                if (inc_s[CNT_W]) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                cool_d  = COOL_W'(GAP - 1);
                state_d = ST_COOL;
            end
            ST_COOL: begin
                if (cool_q == {COOL_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    cool_d = cool_q - {{(COOL_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new request re-arms a flag even in the cycle it is granted; it is
        // only a merge (miss) when the existing flag survives this edge.
        if (man_req_i) begin
            miss_d     = pend_man_q && !grant_man_s;
            pend_man_d = 1'b1;
        end else if (grant_man_s) begin
            pend_man_d = 1'b0;
        end else begin
            pend_man_d = pend_man_q;
        end

        if (auto_req_s) begin
            miss_d      = miss_d || (pend_auto_q && !grant_auto_s);
            pend_auto_d = 1'b1;
        end else if (grant_auto_s) begin
            pend_auto_d = 1'b0;
        end else begin
            pend_auto_d = pend_auto_q;
        end

        if (!auto_en_i) begin
            pend_auto_d = 1'b0;
        end else begin
            pend_auto_d = pend_auto_d;
        end

        // Clear beats everything, including same-cycle requests and a capture
        // that would otherwise commit on this edge.
        if (clr_req_i) begin
            state_d     = ST_IDLE;
            data_d      = {DATA_W{1'b0}};
            count_d     = {CNT_W{1'b0}};
            src_d       = SRC_NONE;
            ovf_d       = 1'b0;
            pend_man_d  = 1'b0;
            pend_auto_d = 1'b0;
            miss_d      = 1'b0;
            cool_d      = {COOL_W{1'b0}};
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            win_q       <= SRC_NONE;
            pend_man_q  <= 1'b0;
            pend_auto_q <= 1'b0;
            rr_q        <= 1'b0;
            data_q      <= {DATA_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            src_q       <= 2'd0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            miss_q      <= 1'b0;
            cool_q      <= {COOL_W{1'b0}};
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            pend_man_q  <= pend_man_d;
            pend_auto_q <= pend_auto_d;
            rr_q        <= rr_d;
            data_q      <= data_d;
            count_q     <= count_d;
            src_q       <= src_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            miss_q      <= miss_d;
            cool_q      <= cool_d;
        end
    end

    assign data_o  = data_q;
    assign count_o = count_q;
    assign src_o   = src_q;
    assign busy_o  = busy_q;
    assign ovf_o   = ovf_q;
    assign miss_o  = miss_q;

endmodule

// File: tb/tb_capture_sched.sv
// tb_capture_sched: directed self-checking bench for capture_sched with
// TICK_DIV=4 and GAP=4. Inputs change 1 time unit after each rising edge and
// outputs are sampled at the same point, so "cycle k" below means the clock
// period in which the bench is currently sitting.
module tb_capture_sched;

    logic       clk = 1'b0;
    logic       rst, man_req, clr_req, auto_en;
    logic [3:0] period;
    logic [9:0] sw;
    logic [9:0] data_o;
    logic [7:0] count_o;
    logic [1:0] src_o;
    logic       busy_o, ovf_o, miss_o;

    int n_cmp = 0;
    int n_bad = 0;

    capture_sched #(.TICK_DIV(4), .GAP(4)) dut (
        .clk100_i  (clk),
        .rst_i     (rst),
        .man_req_i (man_req),
        .clr_req_i (clr_req),
        .auto_en_i (auto_en),
        .period_i  (period),
        .sw_i      (sw),
        .data_o    (data_o),
        .count_o   (count_o),
        .src_o     (src_o),
        .busy_o    (busy_o),
        .ovf_o     (ovf_o),
        .miss_o    (miss_o)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset with a request and a clear asserted alongside: reset must win.
    task automatic test_reset();
        rst = 1'b1; man_req = 1'b1; clr_req = 1'b1; auto_en = 1'b0;
        period = 4'd0; sw = 10'h3FF;
        step(2);
        rst = 1'b0; man_req = 1'b0; clr_req = 1'b0;
        n_cmp++; if (data_o !== 10'h000) begin n_bad++; $display("FAIL rst_data: got %h want %h", data_o, 10'h000); end
        n_cmp++; if (count_o !== 8'h00) begin n_bad++; $display("FAIL rst_count: got %h want %h", count_o, 8'h00); end
        n_cmp++; if (src_o !== 2'd0) begin n_bad++; $display("FAIL rst_src: got %0d want %0d", src_o, 0); end
        n_cmp++; if ({busy_o, ovf_o, miss_o} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want %b", {busy_o, ovf_o, miss_o}, 3'b000); end
        step(8);
        n_cmp++; if (count_o !== 8'h00) begin n_bad++; $display("FAIL rst_no_capture: got %h want %h", count_o, 8'h00); end
    endtask

    // Single manual capture: latency of 3 and six busy cycles.
    task automatic test_manual();
        int bc;
        bc = 0;
        sw = 10'h2A5; man_req = 1'b1;
        step(1);                       // c+1
        man_req = 1'b0;
        bc += int'(busy_o);
        step(1);                       // c+2
        bc += int'(busy_o);
        n_cmp++; if (data_o !== 10'h000) begin n_bad++; $display("FAIL man_early: got %h want %h", data_o, 10'h000); end
        step(1);                       // c+3
        bc += int'(busy_o);
        n_cmp++; if (data_o !== 10'h2A5) begin n_bad++; $display("FAIL man_data: got %h want %h", data_o, 10'h2A5); end
        n_cmp++; if (count_o !== 8'h01) begin n_bad++; $display("FAIL man_count: got %h want %h", count_o, 8'h01); end
        n_cmp++; if (src_o !== 2'd1) begin n_bad++; $display("FAIL man_src: got %0d want %0d", src_o, 1); end
        for (int i = 0; i < 7; i++) begin
            step(1);
            bc += int'(busy_o);
        end
        n_cmp++; if (bc !== 6) begin n_bad++; $display("FAIL man_busy_cycles: got %0d want %0d", bc, 6); end
    endtask

    // Clear wipes outputs and discards a request in the same cycle.
    task automatic test_clr_discard();
        man_req = 1'b1; clr_req = 1'b1;
        step(1);
        man_req = 1'b0; clr_req = 1'b0;
        n_cmp++; if ({data_o, count_o, src_o} !== 20'h0) begin n_bad++; $display("FAIL clr_outputs: got %h want %h", {data_o, count_o, src_o}, 20'h0); end
        step(8);
        n_cmp++; if (count_o !== 8'h00) begin n_bad++; $display("FAIL clr_discard: got %h want %h", count_o, 8'h00); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL clr_idle: got %b want %b", busy_o, 1'b0); end
    endtask

    // Reset while in GRANT aborts the capture entirely.
    task automatic test_reset_mid();
        sw = 10'h3C3; man_req = 1'b1;
        step(1);
        man_req = 1'b0;
        step(1);                       // GRANT
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL rmid_busy: got %b want %b", busy_o, 1'b1); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_cmp++; if (data_o !== 10'h000) begin n_bad++; $display("FAIL rmid_data: got %h want %h", data_o, 10'h000); end
        step(6);
        n_cmp++; if ({count_o, busy_o} !== 9'h000) begin n_bad++; $display("FAIL rmid_no_capture: got %h want %h", {count_o, busy_o}, 9'h000); end
    endtask

    // Manual and auto requests sampled together: manual first, auto after cooldown.
    task automatic test_back_to_back();
        period = 4'd2; auto_en = 1'b0;
        step(1);
        auto_en = 1'b1;                // cycle 0
        step(12);                      // cycle 12: auto request pulse
        man_req = 1'b1; sw = 10'h111;
        step(1);
        man_req = 1'b0;
        step(2);                       // cycle 15
        n_cmp++; if ({data_o, count_o, src_o} !== {10'h111, 8'h01, 2'd1}) begin n_bad++; $display("FAIL b2b_first: got %h want %h", {data_o, count_o, src_o}, {10'h111, 8'h01, 2'd1}); end
        sw = 10'h222;
        step(6);                       // cycle 21
        n_cmp++; if (count_o !== 8'h01) begin n_bad++; $display("FAIL b2b_cool: got %h want %h", count_o, 8'h01); end
        step(1);                       // cycle 22
        n_cmp++; if ({data_o, count_o, src_o} !== {10'h222, 8'h02, 2'd2}) begin n_bad++; $display("FAIL b2b_second: got %h want %h", {data_o, count_o, src_o}, {10'h222, 8'h02, 2'd2}); end
        auto_en = 1'b0;
        step(8);
        n_cmp++; if (count_o !== 8'h02) begin n_bad++; $display("FAIL b2b_stop: got %h want %h", count_o, 8'h02); end
    endtask

    // Clear on the capture edge while an auto request is pending.
    task automatic test_clear_write();
        period = 4'd2;
        step(1);
        auto_en = 1'b1;                // cycle 0
        step(11);
        man_req = 1'b1; sw = 10'h0F0;  // cycle 11
        step(1);
        man_req = 1'b0;                // cycle 12: auto pulse, manual granted
        step(1);                       // cycle 13: GRANT, auto pending
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL cw_grant: got %b want %b", busy_o, 1'b1); end
        clr_req = 1'b1;
        step(1);
        clr_req = 1'b0; auto_en = 1'b0;
        n_cmp++; if ({data_o, count_o, src_o, busy_o, ovf_o, miss_o} !== 23'h0) begin n_bad++; $display("FAIL cw_outputs: got %h want %h", {data_o, count_o, src_o, busy_o, ovf_o, miss_o}, 23'h0); end
        step(10);
        n_cmp++; if ({data_o, count_o, busy_o} !== 19'h0) begin n_bad++; $display("FAIL cw_no_capture: got %h want %h", {data_o, count_o, busy_o}, 19'h0); end
    endtask

    // Auto every 12 cycles; second manual pulse during COOL merges and pulses miss.
    task automatic test_miss();
        period = 4'd2;
        step(1);
        auto_en = 1'b1;                // cycle 0
        step(14);                      // cycle 14
        n_cmp++; if (count_o !== 8'h00) begin n_bad++; $display("FAIL auto_early: got %h want %h", count_o, 8'h00); end
        step(1);                       // cycle 15
        n_cmp++; if ({count_o, src_o} !== {8'h01, 2'd2}) begin n_bad++; $display("FAIL auto_first: got %h want %h", {count_o, src_o}, {8'h01, 2'd2}); end
        step(1);                       // cycle 16
        man_req = 1'b1;
        step(1);                       // cycle 17
        man_req = 1'b0;
        n_cmp++; if (miss_o !== 1'b0) begin n_bad++; $display("FAIL miss_first: got %b want %b", miss_o, 1'b0); end
        step(1);                       // cycle 18
        man_req = 1'b1;
        step(1);                       // cycle 19
        man_req = 1'b0;
        n_cmp++; if (miss_o !== 1'b1) begin n_bad++; $display("FAIL miss_pulse: got %b want %b", miss_o, 1'b1); end
        step(1);                       // cycle 20
        n_cmp++; if (miss_o !== 1'b0) begin n_bad++; $display("FAIL miss_width: got %b want %b", miss_o, 1'b0); end
        step(2);                       // cycle 22
        n_cmp++; if ({count_o, src_o} !== {8'h02, 2'd1}) begin n_bad++; $display("FAIL miss_single_count: got %h want %h", {count_o, src_o}, {8'h02, 2'd1}); end
        step(6);                       // cycle 28
        n_cmp++; if (count_o !== 8'h02) begin n_bad++; $display("FAIL auto2_early: got %h want %h", count_o, 8'h02); end
        step(1);                       // cycle 29
        n_cmp++; if ({count_o, src_o} !== {8'h03, 2'd2}) begin n_bad++; $display("FAIL auto2: got %h want %h", {count_o, src_o}, {8'h03, 2'd2}); end
        step(9);                       // cycle 38
        n_cmp++; if (count_o !== 8'h03) begin n_bad++; $display("FAIL auto3_early: got %h want %h", count_o, 8'h03); end
        step(1);                       // cycle 39
        n_cmp++; if (count_o !== 8'h04) begin n_bad++; $display("FAIL auto3: got %h want %h", count_o, 8'h04); end
        step(12);                      // cycle 51
        n_cmp++; if (count_o !== 8'h05) begin n_bad++; $display("FAIL auto4: got %h want %h", count_o, 8'h05); end
        auto_en = 1'b0;
        step(20);
        n_cmp++; if (count_o !== 8'h05) begin n_bad++; $display("FAIL auto_off: got %h want %h", count_o, 8'h05); end
    endtask

    // Count wrap through FE, FF, 00 with sticky overflow, then clear.
    task automatic test_wrap();
        clr_req = 1'b1;
        step(1);
        clr_req = 1'b0;
        for (int i = 0; i < 254; i++) begin
            man_req = 1'b1; step(1); man_req = 1'b0; step(7);
        end
        n_cmp++; if ({count_o, ovf_o} !== {8'hFE, 1'b0}) begin n_bad++; $display("FAIL wrap_fe: got %h want %h", {count_o, ovf_o}, {8'hFE, 1'b0}); end
        man_req = 1'b1; step(1); man_req = 1'b0; step(7);
        n_cmp++; if ({count_o, ovf_o} !== {8'hFF, 1'b0}) begin n_bad++; $display("FAIL wrap_ff: got %h want %h", {count_o, ovf_o}, {8'hFF, 1'b0}); end
        man_req = 1'b1; step(1); man_req = 1'b0; step(7);
        n_cmp++; if ({count_o, ovf_o} !== {8'h00, 1'b1}) begin n_bad++; $display("FAIL wrap_00: got %h want %h", {count_o, ovf_o}, {8'h00, 1'b1}); end
        man_req = 1'b1; step(1); man_req = 1'b0; step(7);
        n_cmp++; if ({count_o, ovf_o} !== {8'h01, 1'b1}) begin n_bad++; $display("FAIL wrap_sticky: got %h want %h", {count_o, ovf_o}, {8'h01, 1'b1}); end
        clr_req = 1'b1;
        step(1);
        clr_req = 1'b0;
        n_cmp++; if ({count_o, ovf_o} !== {8'h00, 1'b0}) begin n_bad++; $display("FAIL wrap_clr: got %h want %h", {count_o, ovf_o}, {8'h00, 1'b0}); end
    endtask

    initial begin
        rst = 1'b1; man_req = 1'b0; clr_req = 1'b0; auto_en = 1'b0;
        period = 4'd0; sw = 10'h000;
        #1;
        test_reset();
        test_manual();
        test_clr_discard();
        test_reset_mid();
        test_back_to_back();
        test_clear_write();
        test_miss();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
